// File: rtl/decomp_ctrl.sv
// Decompressor control: passes uncompressed fetch words straight through and
// expands compressed words into a run of token-table entries for the decoder.
module decomp_ctrl #(
  parameter int WIDTH   = 32,
  parameter int TT_AW   = 8,
  parameter int CNT_W   = 3,
  parameter int TAG_BIT = WIDTH - 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_word,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             tt_en,
  output logic [TT_AW-1:0] tt_addr,
  input  logic [WIDTH-1:0] tt_data,
  output logic [WIDTH-1:0] out_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_compressed,
  output logic             out_last,
  input  logic             flush,
  output logic             err,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DATA,
    EMIT
  } state_t;

  state_t state, state_next;

  logic [TT_AW-1:0] addr;
  logic [CNT_W:0]   remaining;
  logic [WIDTH-1:0] hold;

  logic             free;
  logic             accept;
  logic             tag;
  logic [CNT_W:0]   count_in;
  logic [TT_AW-1:0] base_in;
  logic [TT_AW:0]   end_addr;
  logic             range_ok;
  logic             start;
  logic             load_pass;
  logic             load_emit;
  logic             err_set;

  // The output register can take a new instruction when it is empty or being drained.
  assign free     = !out_valid || out_ready;
  assign in_ready = (state == IDLE) && free && !flush;
  assign accept   = in_valid && in_ready;

  assign tag      = in_word[TAG_BIT];
  assign count_in = {1'b0, in_word[TT_AW+CNT_W-1:TT_AW]} + (CNT_W+1)'(1);
  assign base_in  = in_word[TT_AW-1:0];
  // One extra bit catches a run that walks off the end of the table.
  assign end_addr = {1'b0, base_in} + (TT_AW+1)'(count_in) - (TT_AW+1)'(1);
  assign range_ok = !end_addr[TT_AW];

  assign tt_en   = (state == READ);
  assign tt_addr = addr;
  assign busy    = (state != IDLE);

  // NOTE: every signal driven here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    load_pass  = 1'b0;
    load_emit  = 1'b0;
    err_set    = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (!tag) begin
            load_pass = 1'b1;
          end else if (range_ok) begin
            start      = 1'b1;
            state_next = READ;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      READ: state_next = DATA;
      DATA: state_next = EMIT;
      EMIT: begin
        if (free) begin
          load_emit  = 1'b1;
          state_next = (remaining != '0) ? READ : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    // Abort beats everything; accept is already blocked through in_ready.
    if (flush) begin
      state_next = IDLE;
      load_emit  = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      addr           <= '0;
      remaining      <= '0;
      // NOTE: hold is a single word register, not a memory, so it is cleared
      // with the rest of the state.
      hold           <= '0;
      out_instr      <= '0;
      out_valid      <= 1'b0;
      out_compressed <= 1'b0;
      out_last       <= 1'b0;
      err            <= 1'b0;
    end else begin
      state <= state_next;
      err   <= err_set;

      if (flush) begin
        remaining <= '0;
      end else if (start) begin
        addr      <= base_in;
        remaining <= count_in;
      end else if (state == DATA) begin
        hold      <= tt_data;
        addr      <= addr + TT_AW'(1);
        remaining <= remaining - (CNT_W+1)'(1);
      end

      if (flush) begin
        out_valid <= 1'b0;
      end else if (load_pass) begin
        out_instr      <= in_word;
        out_valid      <= 1'b1;
        out_compressed <= 1'b0;
        out_last       <= 1'b1;
      end else if (load_emit) begin
        out_instr      <= hold;
        out_valid      <= 1'b1;
        out_compressed <= 1'b1;
        out_last       <= (remaining == '0);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_decomp_ctrl.sv
// Bench for decomp_ctrl: directed scenarios plus a randomized run scored
// against a queue-based model of the expansion rules.
module tb_decomp_ctrl;

  localparam int WIDTH = 32;
  localparam int TT_AW = 8;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] in_word;
  logic             in_valid;
  logic             in_ready;
  logic             tt_en;
  logic [TT_AW-1:0] tt_addr;
  logic [WIDTH-1:0] tt_data = '0;
  logic [WIDTH-1:0] out_instr;
  logic             out_valid;
  logic             out_ready;
  logic             out_compressed;
  logic             out_last;
  logic             flush;
  logic             err;
  logic             busy;

  decomp_ctrl #(.WIDTH(WIDTH), .TT_AW(TT_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .in_word(in_word), .in_valid(in_valid), .in_ready(in_ready),
    .tt_en(tt_en), .tt_addr(tt_addr), .tt_data(tt_data),
    .out_instr(out_instr), .out_valid(out_valid), .out_ready(out_ready),
    .out_compressed(out_compressed), .out_last(out_last),
    .flush(flush), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Synchronous-read token table.
  logic [WIDTH-1:0] tt_mem [256];
  always @(posedge clk) if (tt_en) tt_data <= tt_mem[tt_addr];

  typedef struct {
    logic [31:0] instr;
    logic        cmp;
    logic        last;
  } exp_t;

  exp_t       exp_q  [$];
  logic [7:0] addr_q [$];

  int checks = 0;
  int failures = 0;
  int tt_en_cnt = 0;
  int err_cnt = 0;
  int err_exp = 0;
  int out_cnt = 0;
  int ready_viol = 0;
  bit last_acc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: what an accepted word must produce, straight from the format rules.
  task automatic model_accept(input logic [31:0] word);
    int cnt;
    int base;
    exp_t e;
    if (!word[31]) begin
      e.instr = word; e.cmp = 1'b0; e.last = 1'b1;
      exp_q.push_back(e);
    end else begin
      cnt  = int'(word[10:8]) + 1;
      base = int'(word[7:0]);
      if (base + cnt - 1 > 255) begin
        err_exp++;
      end else begin
        for (int i = 0; i < cnt; i++) begin
          e.instr = tt_mem[base + i]; e.cmp = 1'b1; e.last = (i == cnt - 1);
          exp_q.push_back(e);
          addr_q.push_back(8'(base + i));
        end
      end
    end
  endtask

  // One cycle: sample just after inputs settle, score, then move to the next falling edge.
  task automatic tick();
    exp_t e;
    logic [7:0] a;
    #1;
    if (out_valid && out_ready) begin
      out_cnt++;
      check("sb_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_instr", out_instr, e.instr);
        check("sb_cmp", out_compressed, e.cmp);
        check("sb_last", out_last, e.last);
      end
    end
    if (tt_en) begin
      tt_en_cnt++;
      check("tt_nonempty", addr_q.size() != 0, 1);
      if (addr_q.size() != 0) begin
        a = addr_q.pop_front();
        check("tt_addr", tt_addr, a);
      end
    end
    if (err) err_cnt++;
    last_acc = in_valid && in_ready;
    if (last_acc) model_accept(in_word);
    if (flush) begin
      exp_q.delete();
      addr_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((busy || out_valid) && n < budget) begin
      if (busy && in_ready) ready_viol++;
      tick();
      n++;
    end
    check("drain_done", busy || out_valid, 0);
  endtask

  function automatic logic [31:0] gen_word();
    logic [7:0] base;
    base = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(240, 255)) : 8'($urandom);
    if ($urandom_range(0, 1) == 1)
      return {1'b1, 20'($urandom), 3'($urandom), base};
    return {1'b0, 31'($urandom)};
  endfunction

  initial begin
    int t0, o0, e0, ov, n;
    bit stable;

    for (int i = 0; i < 256; i++) tt_mem[i] = $urandom;
    tt_mem[3] = 32'hA000_0001;
    tt_mem[4] = 32'hB000_0002;
    tt_mem[5] = 32'hC000_0003;

    // Reset held with a valid word presented.
    reset = 1'b0; in_valid = 1'b1; in_word = 32'h1234_5678; out_ready = 1'b1; flush = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_instr", out_instr, 0);
    check("rst_out_cmp", out_compressed, 0);
    check("rst_out_last", out_last, 0);
    check("rst_tt_en", tt_en, 0);
    check("rst_tt_addr", tt_addr, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);

    // Release and pass two words straight through.
    reset = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);
    t0 = tt_en_cnt;
    tick();
    in_word = 32'h0000_ABCD;
    check("pt0_valid", out_valid, 1);
    check("pt0_instr", out_instr, 32'h1234_5678);
    check("pt0_cmp", out_compressed, 0);
    check("pt0_last", out_last, 1);
    tick();
    in_valid = 1'b0;
    check("pt1_valid", out_valid, 1);
    check("pt1_instr", out_instr, 32'h0000_ABCD);
    drain(10);
    check("pt_no_tt", tt_en_cnt - t0, 0);

    // Expansion: count 3 from base 3.
    t0 = tt_en_cnt; o0 = out_cnt;
    in_valid = 1'b1; in_word = 32'h8000_0203;
    tick();
    in_valid = 1'b0;
    check("exp_in_ready", in_ready, 0);
    check("exp_busy", busy, 1);
    tick(); tick();
    check("exp_lat3", out_valid, 0);
    tick();
    check("exp_lat4", out_valid, 1);
    check("exp_A", out_instr, 32'hA000_0001);
    drain(50);
    check("exp_reads", tt_en_cnt - t0, 3);
    check("exp_outs", out_cnt - o0, 3);

    // Backpressure on the first expanded instruction.
    o0 = out_cnt;
    in_valid = 1'b1; in_word = 32'h8000_0203;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin tick(); n++; end
    check("bp_seen", out_valid, 1);
    out_ready = 1'b0; t0 = tt_en_cnt; stable = 1'b1;
    repeat (10) begin
      tick();
      if (!out_valid || out_instr !== 32'hA000_0001) stable = 1'b0;
    end
    check("bp_stable", stable, 1);
    check("bp_one_read", tt_en_cnt - t0, 1);
    check("bp_no_out", out_cnt - o0, 0);
    out_ready = 1'b1;
    drain(50);
    check("bp_outs", out_cnt - o0, 3);

    // Range error: base 0xFE, count 8.
    e0 = err_cnt; t0 = tt_en_cnt; ov = 0;
    in_valid = 1'b1; in_word = 32'h8000_07FE;
    tick();
    in_valid = 1'b0;
    repeat (4) begin
      if (out_valid) ov++;
      tick();
    end
    check("rng_err", err_cnt - e0, 1);
    check("rng_no_tt", tt_en_cnt - t0, 0);
    check("rng_no_out", ov, 0);
    in_valid = 1'b1; in_word = 32'h1234_5678;
    check("rng_next_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("rng_next_valid", out_valid, 1);
    check("rng_next_instr", out_instr, 32'h1234_5678);
    drain(10);

    // Flush one cycle into an expansion.
    in_valid = 1'b1; in_word = 32'h8000_0203;
    tick();
    in_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_valid", out_valid, 0);
    check("fl_busy", busy, 0);
    check("fl_tt_en", tt_en, 0);
    ov = 0;
    repeat (8) begin
      if (out_valid) ov++;
      tick();
    end
    check("fl_no_out", ov, 0);
    in_valid = 1'b1; in_word = 32'h1234_5678;
    tick();
    in_valid = 1'b0;
    check("fl_pt_valid", out_valid, 1);
    check("fl_pt_instr", out_instr, 32'h1234_5678);
    check("fl_pt_cmp", out_compressed, 0);
    drain(10);

    // Randomized traffic with backpressure and occasional flushes.
    last_acc = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!in_valid || last_acc) begin
        in_valid = ($urandom_range(0, 1) == 1);
        in_word  = gen_word();
      end
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 49) == 0);
      tick();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drain(200);

    check("sb_left", exp_q.size(), 0);
    check("tt_left", addr_q.size(), 0);
    check("err_total", err_cnt, err_exp);
    check("ready_viol", ready_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decomp_ctrl.md
Name: decomp_ctrl

Overview:
- Decompressor control unit: sequences instruction expansion between the fetch stream (imem words) and the decoder.
- Uncompressed words pass through unchanged.
- A compressed word carries a base index and a count. The block reads the token table at consecutive addresses and emits one instruction per entry.
- Valid/ready handshakes on both sides; the token-table read port is owned by this block.

Parameters:
WIDTH, 32, instruction/word width
TT_AW, 8, token table address width (depth 2^TT_AW)
CNT_W, 3, count field width (expansion length 1..2^CNT_W)
TAG_BIT, WIDTH-1, bit position marking a compressed word

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
in_word  in  WIDTH  fetched word
in_valid  in  1  in_word valid
in_ready  out  1  block accepts in_word this cycle
tt_en  out  1  token table read enable
tt_addr  out  TT_AW  token table read address
tt_data  in  WIDTH  token table data, valid the cycle after tt_en (synchronous read)
out_instr  out  WIDTH  instruction to decoder
out_valid  out  1  out_instr valid
out_ready  in  1  decoder accepts out_instr
out_compressed  out  1  out_instr came from an expansion
out_last  out  1  last instruction of the current fetch word
flush  in  1  synchronous abort (taken branch)
err  out  1  one-cycle pulse: expansion range out of bounds
busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. While reset=0:
  - state=IDLE
  - out_valid, out_instr, out_compressed, out_last, tt_en, tt_addr, err, busy all 0
  - remaining counter and hold register 0
- Compressed word format: in_word[TAG_BIT]=1.
  - count = in_word[TT_AW+CNT_W-1:TT_AW] + 1
  - base = in_word[TT_AW-1:0]
  - other bits ignored
- Output register: out_* are registered. out_valid stays high, with out_instr stable, until out_valid&&out_ready. The register is "free" when !out_valid || out_ready.
- in_ready = (state==IDLE) && free && !flush (combinational).
- FSM states: IDLE, READ, DATA, EMIT.
- IDLE, on accept (in_valid&&in_ready):
  - Tag=0: out_instr<=in_word, out_valid<=1, out_compressed<=0, out_last<=1; stay IDLE. Back-to-back throughput is 1 word/cycle.
  - Tag=1 and base+count-1 <= 2^TT_AW-1 (computed TT_AW+1 bits wide): addr<=base, remaining<=count; go READ.
  - Tag=1 and out of range: err<=1 for one cycle, word dropped, no tt_en, stay IDLE.
- READ: tt_en=1, tt_addr=addr (registered address); go DATA.
- DATA: hold<=tt_data; addr<=addr+1; remaining<=remaining-1; go EMIT.
- EMIT: when free:
  - out_instr<=hold, out_valid<=1, out_compressed<=1, out_last<=(remaining==0)
  - then go READ if remaining!=0, else IDLE
  - while not free, stay in EMIT; no further tt_en is issued.
- Latency:
  - uncompressed: accept at cycle 0, out_valid at cycle 1
  - compressed: first instruction out_valid at cycle 4 after accept (READ c1, DATA c2, EMIT c3); subsequent instructions every 3 cycles with no backpressure
  - at most one table read is outstanding; no entry is ever read twice
- Flush: highest priority, including over an accept in the same cycle. Next cycle: state=IDLE, out_valid=0, tt_en=0, remaining=0. The pending expansion is discarded; a table read already issued is ignored.
- err is only asserted from IDLE; it never coincides with out_valid rising for the same word.
- busy = (state!=IDLE), registered from state.
- Reset asserted mid-expansion: immediate return to the reset values; no partial output after release.

Test Plan:
- Reset: hold reset=0 for 3 cycles with in_valid=1 -> all outputs 0; after release, in_ready=1 with out_ready=1, first word accepted on the next edge.
- Passthrough: words 0x12345678, 0x0000ABCD back-to-back with out_ready=1 -> out_instr 0x12345678 then 0x0000ABCD on consecutive cycles; out_compressed=0, out_last=1, tt_en never 1.
- Expansion: table[3..5]=0xA0000001/0xB0000002/0xC0000003; in_word 0x80000203 (count 3, base 3) -> tt_addr 3,4,5 in order; outputs A,B,C with out_compressed=1; out_last=1 only on C; in_ready=0 and busy=1 until IDLE.
- Backpressure: same expansion, out_ready=0 for 10 cycles after A appears -> A held stable; exactly one tt_en (addr 4) issued; B appears only after out_ready=1.
- Range error: in_word 0x800007FE (count 8, base 0xFE) -> err=1 for exactly one cycle; no tt_en, no out_valid; next word accepted normally.
- Flush: flush=1 one cycle after A is accepted, mid-expansion -> next cycle out_valid=0 and state IDLE; B and C never emitted; a following 0x12345678 passes through normally.
